// File: rtl/prog_updown_counter_if.sv
// Control/status bundle for prog_updown_counter.
// The controller side drives the commands and the counter side drives the status.
interface prog_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic             enable;
  logic             up_dn;
  logic             auto_reload;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output start, stop, enable, up_dn, auto_reload, load_value,
    input  count, busy, done, tc
  );

  modport slave (
    input  start, stop, enable, up_dn, auto_reload, load_value,
    output count, busy, done, tc
  );
endinterface

// File: rtl/prog_updown_counter.sv
// Start/stop controlled up/down counter with a programmable terminal value.
// It has one-shot and auto-reload modes and a one-cycle terminal-count pulse.
module prog_updown_counter #(
  parameter int WIDTH = 8
) (
  input logic                  clock,
  input logic                  reset,
  prog_updown_counter_if.slave bus
);
  localparam logic [1:0]       IDLE = 2'd0;
  localparam logic [1:0]       RUN  = 2'd1;
  localparam logic [1:0]       DONE = 2'd2;
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic [WIDTH-1:0] l_r, l_s;
  logic             dir_r, dir_s;
  logic             ar_r, ar_s;
  logic             tc_r, tc_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] target_s;

  // Next-state decode: stop beats start, and start beats counting.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    l_s      = l_r;
    dir_s    = dir_r;
    ar_s     = ar_r;
    tc_s     = 1'b0;
    target_s = dir_r ? l_r : ZERO;
    if (bus.stop) begin
      state_s = IDLE;
    end else if (bus.start) begin
      l_s     = bus.load_value;
      dir_s   = bus.up_dn;
      ar_s    = bus.auto_reload;
      count_s = bus.up_dn ? ZERO : bus.load_value;
      state_s = RUN;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        RUN: begin
          if (!bus.enable) begin
            state_s = RUN;
          end else if (count_r == target_s) begin
            tc_s = 1'b1;
            if (ar_r) begin
              count_s = dir_r ? ZERO : l_r;
            end else begin
              state_s = DONE;
            end
          end else begin
            count_s = dir_r ? (count_r + ONE) : (count_r - ONE);
          end
        end
        DONE:    state_s = DONE;
        default: state_s = IDLE;
      endcase
    end
    busy_s = (state_s == RUN);
    done_s = (state_s == DONE);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      count_r <= ZERO;
      l_r     <= ZERO;
      dir_r   <= 1'b0;
      ar_r    <= 1'b0;
      tc_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      l_r     <= l_s;
      dir_r   <= dir_s;
      ar_r    <= ar_s;
      tc_r    <= tc_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.count = count_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.tc    = tc_r;
endmodule

// File: tb/tb_prog_updown_counter.sv
// Randomised self-checking bench for prog_updown_counter.
// It uses a step-count reference model and adds directed checks for the documented scenarios.
module tb_prog_updown_counter;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  prog_updown_counter_if #(.WIDTH(W)) bus ();
  prog_updown_counter #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a run is a count of enabled steps since start.
  int m_mode;   // 0 idle, 1 run, 2 done
  int m_steps;
  int m_l;
  int m_count;
  bit m_dir;
  bit m_ar;
  bit m_tc;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_steps = 0; m_l = 0; m_count = 0;
    m_dir = 1'b0; m_ar = 1'b0; m_tc = 1'b0;
  endtask

  task automatic model_edge();
    m_tc = 1'b0;
    if (bus.stop) begin
      m_mode = 0;
    end else if (bus.start) begin
      m_l = int'(bus.load_value); m_dir = bus.up_dn; m_ar = bus.auto_reload;
      m_steps = 0; m_mode = 1;
      m_count = m_dir ? 0 : m_l;
    end else if (m_mode == 1 && bus.enable) begin
      m_steps++;
      if (m_steps == m_l + 1) begin
        m_tc = 1'b1;
        if (m_ar) m_steps = 0;
        else m_mode = 2;
      end
      if (m_mode == 2) m_count = m_dir ? m_l : 0;
      else m_count = m_dir ? m_steps : m_l - m_steps;
    end
  endtask

  task automatic check_all();
    chk("count", int'(bus.count), m_count);
    chk("busy", int'(bus.busy), int'(m_mode == 1));
    chk("done", int'(bus.done), int'(m_mode == 2));
    chk("tc", int'(bus.tc), int'(m_tc));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic drive(input bit st, input bit sp, input bit en, input bit ud,
                       input bit ar, input int lv);
    bus.start = st; bus.stop = sp; bus.enable = en;
    bus.up_dn = ud; bus.auto_reload = ar; bus.load_value = W'(lv);
  endtask

  task automatic launch(input bit ud, input bit ar, input int lv);
    drive(1'b1, 1'b0, 1'b1, ud, ar, lv);
    tick();
    drive(1'b0, 1'b0, 1'b1, ~ud, ~ar, 255 - lv);
  endtask

  int tcs;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b1;
    model_reset();
    #12;
    @(negedge clock);
    reset = 1'b0;
    check_all();
    chk("reset_count", int'(bus.count), 0);

    // Down, auto-reload, L=3.
    launch(1'b0, 1'b1, 3);
    chk("dn_start_count", int'(bus.count), 3);
    tcs = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      tcs += int'(bus.tc);
      chk("dn_ar_busy", int'(bus.busy), 1);
    end
    chk("dn_ar_tc_total", tcs, 3);
    chk("dn_ar_end_count", int'(bus.count), 3);

    // Up, one-shot, L=5, then restart with L=2.
    launch(1'b1, 1'b0, 5);
    chk("up_start_count", int'(bus.count), 0);
    tcs = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      tcs += int'(bus.tc);
    end
    chk("up_os_tc_total", tcs, 1);
    chk("up_os_done", int'(bus.done), 1);
    chk("up_os_hold", int'(bus.count), 5);
    launch(1'b1, 1'b0, 2);
    chk("up_restart_count", int'(bus.count), 0);
    chk("up_restart_done", int'(bus.done), 0);

    // Enable toggling, L=2 down auto-reload: one tc every 6 cycles.
    launch(1'b0, 1'b1, 2);
    tcs = 0;
    for (int i = 0; i < 18; i++) begin
      bus.enable = (i % 2 == 0);
      tick();
      tcs += int'(bus.tc);
    end
    chk("gate_tc_total", tcs, 3);

    // L=0 auto-reload: tc on every enabled cycle.
    launch(1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("l0_tc", int'(bus.tc), 1);
      chk("l0_count", int'(bus.count), 0);
    end

    // Simultaneous start and stop in RUN.
    launch(1'b0, 1'b1, 7);
    tick(); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9);
    tick();
    chk("startstop_busy", int'(bus.busy), 0);
    chk("startstop_count", int'(bus.count), 5);

    // Restart from RUN at count 4 with L=9.
    launch(1'b0, 1'b0, 6);
    tick(); tick();
    chk("pre_restart", int'(bus.count), 4);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9);
    tick();
    chk("restart_count", int'(bus.count), 9);
    chk("restart_tc", int'(bus.tc), 0);

    // Start coinciding with terminal: no tc.
    bus.start = 1'b0;
    launch(1'b0, 1'b1, 1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4);
    tick();
    chk("start_at_term_tc", int'(bus.tc), 0);
    chk("start_at_term_count", int'(bus.count), 0);

    // Asynchronous reset mid-run at count 5.
    launch(1'b0, 1'b1, 7);
    tick(); tick();
    chk("pre_reset_count", int'(bus.count), 5);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", int'(bus.count), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_tc", int'(bus.tc), 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.start = 1'b0;
    tick();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 6)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
